// File: rtl/axis_burst_memory.sv
// axis_burst_memory: AXI-Stream packet writes with auto-increment and byte strobes,
// burst reads with backpressure. Define AXIS_MEM_STATS_EN to add saturating beat counters.
module axis_burst_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s02_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
    input  logic                    s02_axis_tvalid,
    input  logic                    s02_axis_tlast,
    output logic                    s02_axis_tready,
    input  logic [ADDR_WIDTH-1:0]   s02_axis_wr_addr,
    input  logic                    m02_axis_rd_en,
    input  logic [ADDR_WIDTH-1:0]   m02_axis_rd_addr,
    input  logic [LEN_WIDTH-1:0]    m02_axis_rd_len,
    output logic                    m02_axis_rd_cmd_ready,
    output logic [DATA_WIDTH-1:0]   m02_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m02_axis_tstrb,
    output logic                    m02_axis_tvalid,
    output logic                    m02_axis_tlast,
    input  logic                    m02_axis_tready
`ifdef AXIS_MEM_STATS_EN
    ,
    output logic [31:0]             stat_wr_beats,
    output logic [31:0]             stat_rd_beats
`endif
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  running_q;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_fire;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  issue_done_q, issue_done_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  issue;
    logic                  pop;
    logic [2:0]            load;

    logic [1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [1:0]                 buf_last_q, buf_last_d;
    logic                       wptr_q, wptr_d;
    logic                       rptr_q, rptr_d;
    logic [1:0]                 occ_q, occ_d;

    always_comb begin
        wr_fire  = s02_axis_tvalid && running_q;
        wr_addr  = first_q ? s02_axis_wr_addr : wr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        first_d  = first_q;
        if (wr_fire) begin
            wr_ptr_d = wr_addr + ADDR_WIDTH'(1);
            first_d  = s02_axis_tlast;
        end
    end

    // Storage is not reset; the registered read port returns pre-write data on a collision.
    always_ff @(posedge axis_aclk) begin
        if (issue) begin
            rd_data_q <= mem[rd_addr_q];
        end
        if (wr_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s02_axis_tstrb[i]) begin
                    mem[wr_addr][i*8 +: 8] <= s02_axis_tdata[i*8 +: 8];
                end
            end
        end
    end

    // A read may issue only if its beat is guaranteed a buffer slot when it lands,
    // counting the slot freed by a pop in this same cycle.
    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        count_d         = count_q;
        issue_done_d    = issue_done_q;
        issue           = 1'b0;
        pop             = m02_axis_tvalid && m02_axis_tready;
        load            = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        case (state_q)
            IDLE: begin
                if (m02_axis_rd_en && running_q) begin
                    rd_addr_d    = m02_axis_rd_addr;
                    count_d      = m02_axis_rd_len;
                    issue_done_d = 1'b0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (!issue_done_q && load <= 3'd1) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    if (count_q == '0) begin
                        issue_done_d = 1'b1;
                    end else begin
                        count_d = count_q - LEN_WIDTH'(1);
                    end
                end
                if (pop && buf_last_q[rptr_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d      = issue;
        inflight_last_d = issue && (count_q == '0);
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (inflight_q) begin
            buf_data_d[wptr_q] = rd_data_q;
            buf_last_d[wptr_q] = inflight_last_q;
            wptr_d             = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        occ_d = occ_q + 2'(inflight_q) - 2'(pop);
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            running_q       <= 1'b0;
            first_q         <= 1'b1;
            wr_ptr_q        <= '0;
            state_q         <= IDLE;
            rd_addr_q       <= '0;
            count_q         <= '0;
            issue_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q      <= '0;
            buf_last_q      <= '0;
            wptr_q          <= 1'b0;
            rptr_q          <= 1'b0;
            occ_q           <= '0;
        end else begin
            running_q       <= 1'b1;
            first_q         <= first_d;
            wr_ptr_q        <= wr_ptr_d;
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            count_q         <= count_d;
            issue_done_q    <= issue_done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            occ_q           <= occ_d;
        end
    end

    assign s02_axis_tready       = running_q;
    assign m02_axis_rd_cmd_ready = running_q && (state_q == IDLE);
    assign m02_axis_tvalid       = (occ_q != 2'd0);
    assign m02_axis_tdata        = buf_data_q[rptr_q];
    assign m02_axis_tlast        = m02_axis_tvalid && buf_last_q[rptr_q];
    assign m02_axis_tstrb        = {STRB_WIDTH{m02_axis_tvalid}};

`ifdef AXIS_MEM_STATS_EN
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (wr_fire && stat_wr_q != 32'hFFFF_FFFF) begin
            stat_wr_d = stat_wr_q + 32'd1;
        end
        if (pop && stat_rd_q != 32'hFFFF_FFFF) begin
            stat_rd_d = stat_rd_q + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_beats = stat_wr_q;
    assign stat_rd_beats = stat_rd_q;
`endif

endmodule

// File: doc/axis_burst_memory.md
# axis_burst_memory

Parametrised single-clock AXI-Stream memory block for the lab datapath. Packets arriving on the s02 stream are written at an address given on the first beat, with auto-increment and per-byte strobes. Read commands stream out bursts of 1 to 2^LEN_WIDTH beats on the m02 stream, with full backpressure and TLAST on the final beat. It replaces the fixed 4096×32 single-beat memory between the producer and consumer stages.

## Interface
- DATA_WIDTH, 32: data bus width; must be a multiple of 8.
- ADDR_WIDTH, 12: word address width; depth = 2^ADDR_WIDTH words.
- LEN_WIDTH, 8: read burst length field width; burst = len+1 beats.
- axis_aclk  in  1  single clock; all ports are synchronous to its rising edge.
- axis_aresetn  in  1  asynchronous, active-low reset.
- s02_axis_tdata  in  DATA_WIDTH  write data.
- s02_axis_tstrb  in  DATA_WIDTH/8  byte write enables.
- s02_axis_tvalid  in  1  write beat valid.
- s02_axis_tlast  in  1  last beat of write packet.
- s02_axis_tready  out  1  write ready.
- s02_axis_wr_addr  in  ADDR_WIDTH  start address; sampled on the first beat of a packet only.
- m02_axis_rd_en  in  1  read command valid.
- m02_axis_rd_addr  in  ADDR_WIDTH  burst start address.
- m02_axis_rd_len  in  LEN_WIDTH  burst length minus one.
- m02_axis_rd_cmd_ready  out  1  read command accepted when high with rd_en.
- m02_axis_tdata  out  DATA_WIDTH  read data.
- m02_axis_tstrb  out  DATA_WIDTH/8  always all ones while tvalid is high; 0 otherwise.
- m02_axis_tvalid  out  1  read beat valid.
- m02_axis_tlast  out  1  final beat of burst.
- m02_axis_tready  in  1  downstream ready.

## Operation
- Storage: dual-port array (one write port, one read port), not reset; contents are undefined after power-up.
- Write path:
  - s02_axis_tready is 1 in every cycle out of reset; a beat is accepted on tvalid&tready.
  - A first-beat flag is set at reset and after each accepted tlast beat.
  - On a first beat, the write address is s02_axis_wr_addr. On later beats it is the internal pointer.
  - After each accepted beat, pointer = address+1 modulo 2^ADDR_WIDTH (wraps 4095→0).
  - Byte i is written only if tstrb[i]=1. A beat with tstrb=0 changes no byte but still advances the pointer.
- Read FSM:
  - IDLE: rd_cmd_ready=1. On rd_en, latch addr and count=len, then go to BURST.
  - BURST: rd_cmd_ready=0. Issue one array read per cycle while credit is available. Credit = 2-entry output buffer occupancy + in-flight reads < 2.
  - Each issue increments the read address (wrapping as on the write side) and decrements the remaining count.
  - Go to IDLE in the same cycle the beat tagged last is accepted on m02.
- Output buffer:
  - 2-entry FIFO; the head drives tdata/tlast/tvalid.
  - tlast is set on the beat issued when remaining count = 0.
  - Beats hold stable while tvalid&!tready (AXI rule). No beat is lost or duplicated under any tready pattern.
- Collision: a read and write to the same address in the same cycle returns the old data (read-first).
- Length arithmetic: len is unsigned; len=2^LEN_WIDTH−1 gives 2^LEN_WIDTH beats. A burst may wrap the address space.

## Timing
- Reset (async assert, sync deassert handled upstream): all of the following are 0:
  - s02_axis_tready, m02_axis_tvalid, m02_axis_tlast, m02_axis_tstrb, m02_axis_tdata, m02_axis_rd_cmd_ready.
  - FSM returns to IDLE, the buffer empties, the first-beat flag is set.
  - A burst in progress is discarded. A write packet in progress is abandoned; beats already written persist.
- rd_cmd_ready and s02_axis_tready rise in the first cycle after reset deasserts.
- Write latency: data accepted at edge k is readable by a read issued at edge k+1.
- Read latency: command accepted at edge k → first beat has tvalid=1 after edge k+2.
- Throughput: 1 beat/cycle with tready held high; a burst of N beats has its last beat after edge k+N+1.
- Next command: accepted no earlier than the edge after the last beat's handshake.

## Configuration
- AXIS_MEM_STATS_EN defined:
  - Adds outputs stat_wr_beats and stat_rd_beats, 32 bits each, reset to 0.
  - They count accepted s02 beats and m02 handshakes respectively, saturating at 0xFFFFFFFF.
- AXIS_MEM_STATS_EN not defined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Write 4-beat packet at addr 0x010, data 0xA0..0xA3, tstrb=0xF; read addr 0x010 len 3 → beats 0xA0..0xA3, tlast on the 4th, tvalid after edge k+2.
- Write 0xFFFFFFFF to 0x020, then 0x12345678 with tstrb=0x5 → read returns 0xFF34FF78.
- Write a 3-beat packet at 0xFFE (0x1, 0x2, 0x3) → reading 0xFFE len 2 returns 1, 2, 3 (wrap via 0x000).
- Read len 7 with tready toggling 1,0,0,1,… → exactly 8 beats in order, data stable during stalls, rd_cmd_ready=0 until the 8th handshake.
- Same-cycle read and write of 0x050 (old 0x11, new 0x22) → read returns 0x11; a later read returns 0x22.
- Assert reset mid-burst after 2 of 6 beats → all outputs 0 immediately. After release, a new command reads correct data; no stale beats appear.
